seq_det_sy: RTL
===============

# seq_det_sy

Serial pattern detector that consumes the registered bit stream produced by the synchronous D flip-flop stage (its `q` output drives `din`). It tracks the last N accepted bits, flags each occurrence of a programmable N-bit pattern with a one-cycle pulse, and keeps a saturating match count. Overlapping and non-overlapping detection modes are both supported. It is the first decision stage after the bit-capture flop in the serial-input chain.

## Interface
- `N`, 4, pattern length in bits (2..16)
- `PATTERN`, 4'b1011, pattern to match; MSB is the oldest bit, LSB is the newest bit
- `OVERLAP`, 1, 1 = bits of a completed match may start the next match; 0 = history restarts after a match
- `CNT_W`, 8, width of `match_count`

- `clk`  input  1  clock; all state changes on the rising edge
- `rst`  input  1  reset; **synchronous, active-high**
- `din_valid`  input  1  `din` is accepted at this edge when high
- `din`  input  1  serial data bit (from the flip-flop `q`)
- `clr`  input  1  synchronous clear of `match_count` only
- `detect`  output  1  one-cycle pulse on a pattern match
- `match_count`  output  CNT_W  number of matches, saturating
- `hist`  output  N  last N accepted bits, newest in the LSB (debug)

## Operation
- Reset (`rst`=1 at an edge): `hist`=0, fill counter=0, `detect`=0, `match_count`=0. `rst` has priority over every other input.
- State is held in the fill counter `fill` (0..N, saturates at N). The FSM states are:
  - FILL: `fill`<N. No match is possible.
  - ARMED: `fill`==N.
- Accepting a bit (edge with `din_valid`=1):
  - `hist_next = {hist[N-2:0], din}`.
  - `fill_next = min(fill+1, N)`.
- Match condition: `din_valid`=1, `fill_next`==N, and `hist_next`==PATTERN. The condition uses the bit sampled at this same edge.
- On a match:
  - `detect`=1 for the following cycle.
  - `match_count` increments.
  - If OVERLAP=1, `fill` stays at N.
  - If OVERLAP=0, `fill` goes to 0 and `hist` goes to 0, so N fresh bits are required before the next match.
- Edge with `din_valid`=0: `hist` and `fill` hold, and `detect`=0.
- `match_count` saturates at 2^CNT_W−1. A match at saturation still pulses `detect` but the count holds.
- `clr` priority:
  - `clr`=1 alone sets `match_count` to 0.
  - `clr`=1 together with a match sets `match_count` to 1.
  - `clr` never affects `hist`, `fill`, or `detect`.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Timing
- Latency: the bit that completes the pattern is sampled at edge k. `detect` is high from edge k until edge k+1. `match_count` shows the new value from edge k.
- `detect` is never high for two consecutive cycles unless consecutive accepted bits each complete a match. This is only possible with OVERLAP=1 and a periodic pattern, e.g. 1111.
- Throughput: one bit per clock. `din_valid` gaps stretch the stream without losing history.
- Reset mid-stream: a partial pattern is discarded. After `rst` deasserts, the first match needs N new accepted bits. A pending `detect` is cleared at the reset edge.
- `rst` and `din_valid` high at the same edge: the bit is dropped.
- Upstream contract: `din` is stable around the rising edge. The flip-flop output changes only on `clk` edges, so no synchronizer is required.

## Test plan
- Reset: assert `rst` for 2 cycles while `din_valid`=1 and `din`=1 → `hist`=0, `match_count`=0, `detect`=0, and no match until 4 further bits are accepted.
- Overlap (N=4, PATTERN=1011, OVERLAP=1): stream 1,0,1,1,0,1,1 with `din_valid`=1 → `detect` pulses after bit 4 and bit 7; `match_count`=2.
- Non-overlap (OVERLAP=0): same stream → `detect` only after bit 4; `match_count`=1; `hist`=4'b0011 at the end.
- Valid gaps: stream 1,0,1,1 with `din_valid` low for 3 cycles between bits 2 and 3 → exactly one `detect`, one cycle after bit 4 is accepted.
- Saturation and clear (CNT_W=2): 5 matches → `match_count`=3 and `detect` pulses 5 times. Then `clr` coincident with a 6th match → `match_count`=1.
- Mid-pattern reset: bits 1,0,1, then `rst` for one edge, then bit 1 → no `detect`. The subsequent 1,0,1,1 → `detect` once.

Source files
------------

// File: rtl/seq_det_sy_if.sv
// Bus bundle for the serial pattern detector: bit stream, clear, and the
// registered detect / count / history outputs.
interface seq_det_sy_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    logic             din_valid;
    logic             din;
    logic             clr;
    logic             detect;
    logic [CNT_W-1:0] match_count;
    logic [N-1:0]     hist;

    // Bit source / observer side
    modport master (
        output din_valid,
        output din,
        output clr,
        input  detect,
        input  match_count,
        input  hist
    );

    // Detector side
    modport slave (
        input  din_valid,
        input  din,
        input  clr,
        output detect,
        output match_count,
        output hist
    );
endinterface

// File: rtl/seq_det_sy.sv
// Serial pattern detector fed by the registered bit-capture flop. Tracks the
// last N accepted bits, pulses detect for one cycle on each occurrence of
// PATTERN (MSB oldest), and keeps a saturating match count.
module seq_det_sy #(
    parameter int           N       = 4,
    parameter logic [N-1:0] PATTERN = 4'b1011,
    parameter bit           OVERLAP = 1'b1,
    parameter int           CNT_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_det_sy_if.slave   bus
);
    localparam int FW = $clog2(N + 1);

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [N-1:0]     hist_q, hist_d;
    logic             detect_q, detect_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N-1:0]     hist_acc;
    logic [FW-1:0]    fill_inc;
    logic             full_next;
    logic             match;

    // State register; reset wins over every other input
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            fill_q   <= '0;
            hist_q   <= '0;
            detect_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            hist_q   <= hist_d;
            detect_q <= detect_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state, history shift, match decode and count update
    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        hist_d   = hist_q;
        detect_d = 1'b0;
        cnt_d    = cnt_q;

        hist_acc  = {hist_q[N-2:0], bus.din};
        // ARMED means fill already saturated at N
        fill_inc  = (state_q == ARMED) ? FW'(N) : fill_q + FW'(1);
        full_next = (fill_inc == FW'(N));
        match     = bus.din_valid && full_next && (hist_acc == PATTERN);

        if (bus.din_valid) begin
            if (match && !OVERLAP) begin
                // Non-overlapping: a completed match restarts the history
                hist_d  = '0;
                fill_d  = '0;
                state_d = FILL;
            end else begin
                hist_d  = hist_acc;
                fill_d  = fill_inc;
                state_d = full_next ? ARMED : FILL;
            end
        end

        detect_d = match;

        if (bus.clr) begin
            cnt_d = match ? CNT_W'(1) : '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign bus.detect      = detect_q;
    assign bus.match_count = cnt_q;
    assign bus.hist        = hist_q;
endmodule
